// File: rtl/axis_pkt_fifo_pkg.sv
// Shared constants for the store-and-forward AXI-Stream packet FIFO.
// Default widths and the cut-through FSM state encoding.
package axis_pkt_fifo_pkg;

  localparam int unsigned AXIS_DATA_W = 32;
  localparam int unsigned AXIS_DEPTH  = 64;

  // Buffering mode: whole packets only, or drain-as-arrive for oversize packets
  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_CUT    = 1'b1;

endpackage

// File: rtl/axis_pkt_fifo_if.sv
// AXI-Stream handshake bundle used on both sides of the packet FIFO.
interface axis_pkt_fifo_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_pkt_fifo_sdp_ram.sv
// Simple dual-port buffer RAM: one synchronous write port, one asynchronous read port.
module axis_pkt_fifo_sdp_ram #(
  parameter  int unsigned WIDTH  = 33,
  parameter  int unsigned DEPTH  = 64,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rd_data_c_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rd_data_c_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO; releases a packet only once its tlast is buffered,
// falling back to cut-through (with a sticky flag) when a packet cannot fit.
module axis_pkt_fifo
  import axis_pkt_fifo_pkg::*;
#(
  parameter  int unsigned DATA_W = AXIS_DATA_W,
  parameter  int unsigned DEPTH  = AXIS_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              axis_aclk,
  input  logic              axis_aresetn,
  axis_pkt_fifo_if.slave    s_axis,
  axis_pkt_fifo_if.master   m_axis,
  output logic [ADDR_W:0]   pkt_count,
  output logic [ADDR_W:0]   fill_level,
  output logic              oversize
);

  localparam int unsigned     PTR_W   = ADDR_W + 1;
  localparam int unsigned     WORD_W  = DATA_W + 1;
  localparam logic [ADDR_W:0] DEPTH_P = PTR_W'(DEPTH);

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   pkt_cnt_q, pkt_cnt_d, fill_q, fill_d;
  logic [0:0]        state_q, state_d;
  logic              oversize_q, oversize_d;
  logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [WORD_W-1:0] head_word;
  logic              full, empty, wr_en, rd_ok, rd_en, head_last;

  assign full          = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
  assign empty         = wr_ptr_q == rd_ptr_q;
  assign s_axis.tready = ~full & axis_aresetn;
  assign wr_en         = s_axis.tvalid & s_axis.tready;
  assign head_last     = head_word[DATA_W];
  assign rd_ok         = ~empty & ((pkt_cnt_q != '0) | (state_q == ST_CUT));
  assign rd_en         = rd_ok & (~out_valid_q | m_axis.tready);

  axis_pkt_fifo_sdp_ram #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i       (axis_aclk),
    .we_i        (wr_en),
    .waddr_i     (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i     ({s_axis.tlast, s_axis.tdata}),
    .raddr_i     (rd_ptr_q[ADDR_W-1:0]),
    .rd_data_c_o (head_word)
  );

  // Pointers, counters and the output register stage
  always_comb begin
    wr_ptr_d    = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d    = rd_ptr_q + PTR_W'(rd_en);
    fill_d      = fill_q + PTR_W'(wr_en) - PTR_W'(rd_en);
    pkt_cnt_d   = pkt_cnt_q + PTR_W'(wr_en & s_axis.tlast) - PTR_W'(rd_en & head_last);
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    if (rd_en) begin
      out_valid_d = 1'b1;
      out_last_d  = head_last;
      out_data_d  = head_word[DATA_W-1:0];
    end else if (m_axis.tready) begin
      out_valid_d = 1'b0;
    end
  end

  // A full buffer with no complete packet can only drain as cut-through
  always_comb begin
    state_d    = state_q;
    oversize_d = oversize_q;
    case (state_q)
      ST_NORMAL: begin
        if (full && (pkt_cnt_q == '0)) begin
          state_d    = ST_CUT;
          oversize_d = 1'b1;
        end
      end
      ST_CUT: begin
        if (rd_en && head_last) state_d = ST_NORMAL;
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_cnt_q   <= '0;
      fill_q      <= '0;
      state_q     <= ST_NORMAL;
      oversize_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_cnt_q   <= pkt_cnt_d;
      fill_q      <= fill_d;
      state_q     <= state_d;
      oversize_q  <= oversize_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Output data needs no reset: it is qualified by out_valid_q
  always_ff @(posedge axis_aclk) begin
    out_data_q <= out_data_d;
  end

  assign m_axis.tdata  = out_data_q;
  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tlast  = out_last_q;
  assign pkt_count     = pkt_cnt_q;
  assign fill_level    = fill_q;
  assign oversize      = oversize_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: scenario tasks against an in-order word scoreboard with
// packet-completeness tracking, plus random packet traffic and random sink stalls.
module tb_axis_pkt_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axis_pkt_fifo_if #(.DATA_W(DW)) s_if ();
  axis_pkt_fifo_if #(.DATA_W(DW)) m_if ();
  logic [AW:0] pkt_count, fill_level;
  logic        oversize;

  axis_pkt_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .axis_aclk    (clk),
    .axis_aresetn (rst_n),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .pkt_count    (pkt_count),
    .fill_level   (fill_level),
    .oversize     (oversize)
  );

  typedef struct { logic [DW-1:0] data; logic last; } word_t;
  typedef struct { logic [DW-1:0] data; logic last; int cyc; bit complete; } beat_t;

  word_t exp_q[$];
  beat_t out_q[$];
  int    chk_exp = 0, chk_out = 0;
  int    vectors = 0, miscompares = 0;
  int    cyc, acc_last, out_last;
  int    sink_mode = 0;
  logic  sink_force = 1'b0;

  // Observer: records accepted input words and delivered output beats.
  // A beat is "complete" when its packet's tlast had already been accepted.
  initial begin
    cyc = 0; acc_last = 0; out_last = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        acc_last = 0;
        out_last = 0;
      end else begin
        if (m_if.tvalid && m_if.tready) begin
          beat_t b;
          b.data = m_if.tdata; b.last = m_if.tlast; b.cyc = cyc; b.complete = (acc_last > out_last);
          out_q.push_back(b);
          if (m_if.tlast) out_last++;
        end
        if (s_if.tvalid && s_if.tready) begin
          word_t w;
          w.data = s_if.tdata; w.last = s_if.tlast;
          exp_q.push_back(w);
          if (s_if.tlast) acc_last++;
        end
      end
    end
  end

  // Sink ready generator: 0 always, 1 random, 2 stalled, 3 driven by sink_force
  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (sink_mode)
        0:       m_if.tready = 1'b1;
        1:       m_if.tready = ($urandom_range(0, 3) != 0);
        2:       m_if.tready = 1'b0;
        default: m_if.tready = sink_force;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic l, input int gap);
    int t;
    s_if.tvalid = 1'b0;
    repeat (gap) tick();
    s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tlast = l;
    t = 0;
    while (1) begin
      bit acc;
      @(negedge clk);
      acc = s_if.tready;
      tick();
      if (acc) break;
      t++;
      if (t > 2000) begin
        vectors++; miscompares++;
        $display("FAIL send_timeout: word %h not accepted, got tready=0 want 1", d);
        break;
      end
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic send_pkt(input logic [DW-1:0] base, input int len, input bit rnd, input int gap_max);
    for (int i = 0; i < len; i++)
      send_word(rnd ? DW'($urandom) : base + DW'(i), i == len - 1,
                gap_max > 0 ? int'($urandom_range(0, gap_max)) : 0);
  endtask

  task automatic wait_valid(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (m_if.tvalid) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic drain(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if ((out_q.size() - chk_out) == (exp_q.size() - chk_exp) && !m_if.tvalid && fill_level == '0) begin
        ok = 1'b1; break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (s_if.tready !== 1'b0 || m_if.tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: got tready=%b tvalid=%b want 0/0", s_if.tready, m_if.tvalid);
    end
    @(posedge clk); #3 rst_n = 1'b1;
    #1;
    vectors++;
    if (s_if.tready !== 1'b1) begin
      miscompares++; $display("FAIL reset_tready: got %b want 1", s_if.tready);
    end
    vectors++;
    if (pkt_count !== '0 || fill_level !== '0 || oversize !== 1'b0 || m_if.tvalid !== 1'b0 || m_if.tlast !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: got pkt=%0d fill=%0d ovs=%b tvalid=%b tlast=%b want all 0",
               pkt_count, fill_level, oversize, m_if.tvalid, m_if.tlast);
    end
  endtask

  task automatic test_single_packet();
    bit ok;
    int first;
    sink_mode = 0;
    tick();
    first = chk_out;
    for (int i = 0; i < 3; i++) send_word(32'hA0 + DW'(i), 1'b0, 0);
    vectors++;
    if (pkt_count !== '0 || m_if.tvalid !== 1'b0) begin
      miscompares++; $display("FAIL single_early: got pkt=%0d tvalid=%b want 0/0", pkt_count, m_if.tvalid);
    end
    send_word(32'hA3, 1'b1, 0);
    vectors++;
    if (pkt_count !== 7'd1 || m_if.tvalid !== 1'b0) begin
      miscompares++; $display("FAIL single_count: got pkt=%0d tvalid=%b want 1/0", pkt_count, m_if.tvalid);
    end
    tick();
    vectors++;
    if (m_if.tvalid !== 1'b1 || m_if.tdata !== 32'hA0) begin
      miscompares++; $display("FAIL single_latency: got tvalid=%b data=%h want 1/a0", m_if.tvalid, m_if.tdata);
    end
    drain(100, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL single_drain: got timeout want drained"); end
    while (chk_exp < exp_q.size()) begin
      vectors++;
      if (out_q[chk_out].data !== exp_q[chk_exp].data || out_q[chk_out].last !== exp_q[chk_exp].last ||
          !out_q[chk_out].complete || (chk_out > first && out_q[chk_out].cyc != out_q[chk_out-1].cyc + 1)) begin
        miscompares++;
        $display("FAIL single_beat %0d: got %h/%b cmpl=%b want %h/%b contiguous complete", chk_out - first,
                 out_q[chk_out].data, out_q[chk_out].last, out_q[chk_out].complete, exp_q[chk_exp].data, exp_q[chk_exp].last);
      end
      chk_exp++; chk_out++;
    end
    vectors++;
    if (pkt_count !== '0) begin miscompares++; $display("FAIL single_final_count: got %0d want 0", pkt_count); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int first;
    sink_mode = 2;
    tick();
    first = chk_out;
    send_pkt(32'hC0, 3, 1'b0, 0);
    send_pkt(32'hD0, 5, 1'b0, 0);
    tick(); tick();
    vectors++;
    if (pkt_count !== 7'd2 || fill_level !== 7'd7 || m_if.tvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_buffered: got pkt=%0d fill=%0d tvalid=%b want 2/7/1", pkt_count, fill_level, m_if.tvalid);
    end
    sink_mode = 0;
    drain(100, ok);
    vectors++;
    if (!ok || out_q.size() - first != 8) begin
      miscompares++; $display("FAIL b2b_drain: got %0d beats ok=%b want 8", out_q.size() - first, ok);
    end
    while (chk_exp < exp_q.size()) begin
      vectors++;
      if (out_q[chk_out].data !== exp_q[chk_exp].data || out_q[chk_out].last !== exp_q[chk_exp].last ||
          !out_q[chk_out].complete || (chk_out > first && out_q[chk_out].cyc != out_q[chk_out-1].cyc + 1)) begin
        miscompares++;
        $display("FAIL b2b_beat %0d: got %h/%b cyc=%0d want %h/%b contiguous", chk_out - first,
                 out_q[chk_out].data, out_q[chk_out].last, out_q[chk_out].cyc, exp_q[chk_exp].data, exp_q[chk_exp].last);
      end
      chk_exp++; chk_out++;
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [DW-1:0] held_d;
    logic          held_l;
    logic [AW:0]   fill0;
    sink_mode = 2;
    tick();
    send_pkt(32'hB0, 6, 1'b0, 0);
    wait_valid(10, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL bp_first_valid: got tvalid=0 want 1"); end
    held_d = m_if.tdata; held_l = m_if.tlast; fill0 = fill_level;
    fork
      for (int p = 0; p < 8; p++) send_pkt('0, 8, 1'b1, 0);
      begin
        bit stalled;
        for (int c = 0; c < 10; c++) begin
          tick();
          vectors++;
          if (m_if.tvalid !== 1'b1 || m_if.tdata !== held_d || m_if.tlast !== held_l) begin
            miscompares++;
            $display("FAIL bp_stable c%0d: got %b/%h/%b want 1/%h/%b", c, m_if.tvalid, m_if.tdata, m_if.tlast, held_d, held_l);
          end
        end
        vectors++;
        if (fill_level <= fill0) begin
          miscompares++; $display("FAIL bp_fill_rise: got %0d want > %0d", fill_level, fill0);
        end
        stalled = 1'b0;
        for (int c = 0; c < 200 && !stalled; c++) begin
          if (s_if.tready === 1'b0) stalled = 1'b1; else tick();
        end
        vectors++;
        if (!stalled || fill_level !== 7'd64) begin
          miscompares++; $display("FAIL bp_full: got stalled=%b fill=%0d want 1/64", stalled, fill_level);
        end
        sink_mode = 0;
      end
    join
    drain(500, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL bp_drain: got timeout want drained"); end
    while (chk_exp < exp_q.size()) begin
      vectors++;
      if (out_q[chk_out].data !== exp_q[chk_exp].data || out_q[chk_out].last !== exp_q[chk_exp].last || !out_q[chk_out].complete) begin
        miscompares++;
        $display("FAIL bp_beat %0d: got %h/%b want %h/%b", chk_exp, out_q[chk_out].data, out_q[chk_out].last,
                 exp_q[chk_exp].data, exp_q[chk_exp].last);
      end
      chk_exp++; chk_out++;
    end
    vectors++;
    if (oversize !== 1'b0) begin miscompares++; $display("FAIL bp_oversize: got %b want 0", oversize); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    sink_mode = 3; sink_force = 1'b0;
    tick(); tick();
    send_word(32'hE0, 1'b0, 0);
    send_word(32'hE1, 1'b1, 0);
    send_word(32'hF0, 1'b0, 0);
    wait_valid(10, ok);
    tick();
    vectors++;
    if (!ok || pkt_count !== 7'd1) begin
      miscompares++; $display("FAIL sim_setup: got valid=%b pkt=%0d want 1/1", ok, pkt_count);
    end
    s_if.tvalid = 1'b1; s_if.tdata = 32'hF1; s_if.tlast = 1'b1; sink_force = 1'b1;
    tick();
    s_if.tvalid = 1'b0; sink_force = 1'b0;
    vectors++;
    if (pkt_count !== 7'd1 || m_if.tdata !== 32'hE1 || m_if.tlast !== 1'b1) begin
      miscompares++;
      $display("FAIL sim_count: got pkt=%0d out=%h/%b want 1/e1/1", pkt_count, m_if.tdata, m_if.tlast);
    end
    sink_mode = 0;
    drain(100, ok);
    // Exactly-full buffer holding one complete packet must not enter cut-through
    sink_mode = 2;
    tick();
    send_pkt(32'h300, 64, 1'b0, 0);
    vectors++;
    if (fill_level !== 7'd64 || pkt_count !== 7'd1 || s_if.tready !== 1'b0) begin
      miscompares++;
      $display("FAIL full64: got fill=%0d pkt=%0d tready=%b want 64/1/0", fill_level, pkt_count, s_if.tready);
    end
    tick();
    vectors++;
    if (oversize !== 1'b0 || m_if.tvalid !== 1'b1 || fill_level !== 7'd63) begin
      miscompares++;
      $display("FAIL full64_nocut: got ovs=%b tvalid=%b fill=%0d want 0/1/63", oversize, m_if.tvalid, fill_level);
    end
    sink_mode = 0;
    drain(300, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL sim_drain: got timeout want drained"); end
    while (chk_exp < exp_q.size()) begin
      vectors++;
      if (out_q[chk_out].data !== exp_q[chk_exp].data || out_q[chk_out].last !== exp_q[chk_exp].last || !out_q[chk_out].complete) begin
        miscompares++;
        $display("FAIL sim_beat %0d: got %h/%b want %h/%b", chk_exp, out_q[chk_out].data, out_q[chk_out].last,
                 exp_q[chk_exp].data, exp_q[chk_exp].last);
      end
      chk_exp++; chk_out++;
    end
  endtask

  task automatic test_random();
    bit ok;
    sink_mode = 1;
    for (int p = 0; p < 12; p++) send_pkt('0, int'($urandom_range(1, 20)), 1'b1, 2);
    drain(3000, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rand_drain: got timeout want drained"); end
    while (chk_exp < exp_q.size()) begin
      vectors++;
      if (out_q[chk_out].data !== exp_q[chk_exp].data || out_q[chk_out].last !== exp_q[chk_exp].last || !out_q[chk_out].complete) begin
        miscompares++;
        $display("FAIL rand_beat %0d: got %h/%b cmpl=%b want %h/%b complete", chk_exp, out_q[chk_out].data,
                 out_q[chk_out].last, out_q[chk_out].complete, exp_q[chk_exp].data, exp_q[chk_exp].last);
      end
      chk_exp++; chk_out++;
    end
    vectors++;
    if (oversize !== 1'b0) begin miscompares++; $display("FAIL rand_oversize: got %b want 0", oversize); end
  endtask

  task automatic test_oversize();
    bit ok;
    sink_mode = 0;
    fork
      send_pkt(32'h1000, 100, 1'b0, 0);
      begin
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < 300 && !hit; c++) begin
          if (fill_level == 7'd64) hit = 1'b1; else tick();
        end
        vectors++;
        if (!hit || oversize !== 1'b0) begin
          miscompares++; $display("FAIL ovs_full: got hit=%b ovs=%b want 1/0", hit, oversize);
        end
        tick();
        vectors++;
        if (oversize !== 1'b1) begin miscompares++; $display("FAIL ovs_set: got %b want 1", oversize); end
      end
    join
    drain(1000, ok);
    vectors++;
    if (!ok || (exp_q.size() - chk_exp) != 100) begin
      miscompares++; $display("FAIL ovs_drain: got ok=%b words=%0d want 1/100", ok, exp_q.size() - chk_exp);
    end
    while (chk_exp < exp_q.size()) begin
      vectors++;
      if (out_q[chk_out].data !== exp_q[chk_exp].data || out_q[chk_out].last !== exp_q[chk_exp].last) begin
        miscompares++;
        $display("FAIL ovs_beat %0d: got %h/%b want %h/%b", chk_exp, out_q[chk_out].data, out_q[chk_out].last,
                 exp_q[chk_exp].data, exp_q[chk_exp].last);
      end
      chk_exp++; chk_out++;
    end
    // Next packet must be held again, proving cut-through ended with the oversize packet
    for (int i = 0; i < 3; i++) send_word(32'h51 + DW'(i), 1'b0, 0);
    tick(); tick(); tick();
    vectors++;
    if (m_if.tvalid !== 1'b0 || fill_level !== 7'd3 || oversize !== 1'b1) begin
      miscompares++;
      $display("FAIL ovs_after: got tvalid=%b fill=%0d ovs=%b want 0/3/1", m_if.tvalid, fill_level, oversize);
    end
    send_word(32'h54, 1'b1, 0);
    drain(100, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL ovs_next_drain: got timeout want drained"); end
    while (chk_exp < exp_q.size()) begin
      vectors++;
      if (out_q[chk_out].data !== exp_q[chk_exp].data || out_q[chk_out].last !== exp_q[chk_exp].last || !out_q[chk_out].complete) begin
        miscompares++;
        $display("FAIL ovs_next_beat %0d: got %h/%b want %h/%b", chk_exp, out_q[chk_out].data, out_q[chk_out].last,
                 exp_q[chk_exp].data, exp_q[chk_exp].last);
      end
      chk_exp++; chk_out++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    sink_mode = 2;
    tick();
    send_pkt(32'h700, 3, 1'b0, 0);
    send_pkt(32'h710, 3, 1'b0, 0);
    wait_valid(10, ok);
    tick();
    vectors++;
    if (!ok || pkt_count !== 7'd2 || fill_level !== 7'd5) begin
      miscompares++;
      $display("FAIL rmid_setup: got valid=%b pkt=%0d fill=%0d want 1/2/5", ok, pkt_count, fill_level);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (m_if.tvalid !== 1'b0 || pkt_count !== '0 || fill_level !== '0 || s_if.tready !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_async: got tvalid=%b pkt=%0d fill=%0d tready=%b want 0/0/0/0",
               m_if.tvalid, pkt_count, fill_level, s_if.tready);
    end
    chk_exp = exp_q.size();
    chk_out = out_q.size();
    @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
    #1;
    vectors++;
    if (s_if.tready !== 1'b1 || oversize !== 1'b0) begin
      miscompares++; $display("FAIL rmid_release: got tready=%b ovs=%b want 1/0", s_if.tready, oversize);
    end
    sink_mode = 0;
    send_pkt(32'h800, 4, 1'b0, 0);
    drain(100, ok);
    vectors++;
    if (!ok || (exp_q.size() - chk_exp) != 4) begin
      miscompares++; $display("FAIL rmid_drain: got ok=%b words=%0d want 1/4", ok, exp_q.size() - chk_exp);
    end
    while (chk_exp < exp_q.size()) begin
      vectors++;
      if (out_q[chk_out].data !== exp_q[chk_exp].data || out_q[chk_out].last !== exp_q[chk_exp].last || !out_q[chk_out].complete) begin
        miscompares++;
        $display("FAIL rmid_beat %0d: got %h/%b want %h/%b", chk_exp, out_q[chk_out].data, out_q[chk_out].last,
                 exp_q[chk_exp].data, exp_q[chk_exp].last);
      end
      chk_exp++; chk_out++;
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_backpressure();
    test_simultaneous();
    test_random();
    test_oversize();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
